// File: rtl/rs_alu.sv
// Reservation station for the ALU/branch execute stage, snooping the CDB for wake-up.
// Optional RS_SECOND_CDB_EN adds a second (load/store) broadcast bus, checked alongside the first.
module rs_alu #(
    parameter int Q_WIDTH = 5,
    parameter int RS_SIZE = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    input  logic               disp_valid,
    input  logic [9:0]         disp_op,
    input  logic [31:0]        disp_V1,
    input  logic [31:0]        disp_V2,
    input  logic [Q_WIDTH-1:0] disp_Q1,
    input  logic [Q_WIDTH-1:0] disp_Q2,
    input  logic [31:0]        disp_imm,
    input  logic [31:0]        disp_npc,
    input  logic [Q_WIDTH-1:0] disp_tag,
    output logic               full,
    input  logic               cdb_valid,
    input  logic [Q_WIDTH-1:0] cdb_tag,
    input  logic [31:0]        cdb_value,
`ifdef RS_SECOND_CDB_EN
    input  logic               cdb2_valid,
    input  logic [Q_WIDTH-1:0] cdb2_tag,
    input  logic [31:0]        cdb2_value,
`endif
    output logic               ex_valid,
    output logic [9:0]         ex_op,
    output logic [31:0]        ex_V1,
    output logic [31:0]        ex_V2,
    output logic [31:0]        ex_imm,
    output logic [31:0]        ex_npc,
    output logic [Q_WIDTH-1:0] ex_tag
);

    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q;
    logic [RS_SIZE-1:0] busy_d;
    logic [RS_SIZE-1:0] ready;
    logic [9:0]         op_q  [RS_SIZE];
    logic [31:0]        v1_q  [RS_SIZE];
    logic [31:0]        v2_q  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        npc_q [RS_SIZE];
    logic [Q_WIDTH-1:0] q1_q  [RS_SIZE];
    logic [Q_WIDTH-1:0] q2_q  [RS_SIZE];
    logic [Q_WIDTH-1:0] tag_q [RS_SIZE];
    logic [31:0]        v1_d  [RS_SIZE];
    logic [31:0]        v2_d  [RS_SIZE];
    logic [Q_WIDTH-1:0] q1_d  [RS_SIZE];
    logic [Q_WIDTH-1:0] q2_d  [RS_SIZE];

    logic [Q_WIDTH-1:0] dq1, dq2;
    logic [31:0]        dv1, dv2;
    logic [IW-1:0]      iss_idx, free_idx;
    logic               iss_any, disp_ok;

    // Resolve one operand against the broadcast bus(es); the second bus wins a double match.
    function automatic logic [Q_WIDTH+31:0] snoop(
        input logic [Q_WIDTH-1:0] q,
        input logic [31:0]        v
    );
        logic [Q_WIDTH+31:0] r;
        r = {q, v};
        if (q != '0 && cdb_valid && cdb_tag == q)
            r = {{Q_WIDTH{1'b0}}, cdb_value};
`ifdef RS_SECOND_CDB_EN
        if (q != '0 && cdb2_valid && cdb2_tag == q)
            r = {{Q_WIDTH{1'b0}}, cdb2_value};
`endif
        return r;
    endfunction

    assign full    = &busy_q;
    assign disp_ok = disp_valid && !full;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0;
            {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i]);
            {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i]);
        end
        {dq1, dv1} = snoop(disp_Q1, disp_V1);
        {dq2, dv2} = snoop(disp_Q2, disp_V2);
    end

    // Lowest-index select for both issue and free slot; the issuing slot is
    // still busy here, so a same-cycle dispatch never lands on it.
    always_comb begin
        iss_any  = 1'b0;
        iss_idx  = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                iss_any = 1'b1;
                iss_idx = IW'(i);
            end
            if (!busy_q[i])
                free_idx = IW'(i);
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (iss_any)
            busy_d[iss_idx] = 1'b0;
        if (disp_ok)
            busy_d[free_idx] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q   <= '0;
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_V1    <= '0;
            ex_V2    <= '0;
            ex_imm   <= '0;
            ex_npc   <= '0;
            ex_tag   <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy_q   <= '0;
                ex_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    q1_q[i] <= q1_d[i];
                    v1_q[i] <= v1_d[i];
                    q2_q[i] <= q2_d[i];
                    v2_q[i] <= v2_d[i];
                end
                ex_valid <= iss_any;
                if (iss_any) begin
                    ex_op  <= op_q[iss_idx];
                    ex_V1  <= v1_q[iss_idx];
                    ex_V2  <= v2_q[iss_idx];
                    ex_imm <= imm_q[iss_idx];
                    ex_npc <= npc_q[iss_idx];
                    ex_tag <= tag_q[iss_idx];
                end
                if (disp_ok) begin
                    op_q[free_idx]  <= disp_op;
                    imm_q[free_idx] <= disp_imm;
                    npc_q[free_idx] <= disp_npc;
                    tag_q[free_idx] <= disp_tag;
                    q1_q[free_idx]  <= dq1;
                    v1_q[free_idx]  <= dv1;
                    q2_q[free_idx]  <= dq2;
                    v2_q[free_idx]  <= dv2;
                end
                busy_q <= busy_d;
            end
        end
    end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station in front of the ALU execute stage of the Tomasulo core.
- Holds dispatched ALU/branch/jump instructions until both source operands are valid, snooping the common data bus (CDB) for wake-up.
- Issues at most one ready instruction per cycle as a registered packet: op, V1, V2, immediate, npc, ROB tag.
- Tag 0 means "no dependency"; ROB tags are 1..2^Q_WIDTH-1.

Parameters:
- Q_WIDTH, 5: width of ROB/dependency tags; tag 0 reserved as "value ready".
- RS_SIZE, 8: number of entries, power of two, 2..16.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state holds
- clear_in  input  1  misprediction flush, synchronous
- disp_valid  input  1  dispatch request this cycle
- disp_op  input  10  decoded op ({type[2:0], opcode class[2:0], funct[3:0]})
- disp_V1, disp_V2  input  32 each  operand values (meaningful when matching Q is 0)
- disp_Q1, disp_Q2  input  Q_WIDTH each  operand producer tags, 0 = ready
- disp_imm  input  32  immediate
- disp_npc  input  32  instruction pc
- disp_tag  input  Q_WIDTH  destination ROB tag
- full  output  1  all entries busy (combinational from busy bits)
- cdb_valid  input  1  CDB broadcast valid
- cdb_tag  input  Q_WIDTH  broadcast tag
- cdb_value  input  32  broadcast value
- ex_valid  output  1  issue packet valid
- ex_op  output  10  to EX op
- ex_V1, ex_V2, ex_imm, ex_npc  output  32 each  to EX operands
- ex_tag  output  Q_WIDTH  ROB tag of issued instruction

Behaviour:
- Reset (rst_in=1 at posedge):
  - all busy bits 0, ex_valid=0, ex_op=0, ex_V1=ex_V2=ex_imm=ex_npc=0, ex_tag=0.
  - Reset has priority over everything; reset mid-operation discards all entries.
- Priority order at each posedge: rst_in > !rdy_in (hold every register) > clear_in (same effect as reset on busy bits and ex_valid; data outputs may hold) > normal operation.
- Dispatch:
  - Accepted when disp_valid && !full. Written into the lowest-index non-busy entry; busy set.
  - Ignored when full; upstream must hold its request.
  - full reflects current busy bits only: a slot freed by issue in the same cycle is not visible until the next cycle.
- Same-cycle bypass at dispatch: if cdb_valid and cdb_tag == disp_Qx (Qx != 0), the entry stores Qx=0 and Vx=cdb_value.
- Wake-up: for every busy entry with Qx == cdb_tag, Qx != 0, cdb_valid → Vx <= cdb_value, Qx <= 0 at the posedge.
- Ready condition: busy && Q1==0 && Q2==0, evaluated on registered state. A woken entry therefore issues no earlier than the cycle after the broadcast.
- Issue (select, registered):
  - Choose the lowest-index ready entry.
  - At the posedge, load the ex_* outputs from it, set ex_valid=1 and clear its busy bit.
  - If no entry is ready, ex_valid=0.
- Latency: an entry dispatched with both Q=0 at edge N issues (ex_valid high) after edge N+1. ex_valid is high for exactly one cycle per issue.
- Simultaneous dispatch and issue: both take effect; the dispatched entry goes to the lowest free index excluding the issuing entry's slot.
- Tag 0 on the CDB never wakes anything.

Optional Feature:
- RS_SECOND_CDB_EN:
  - Defined: adds ports cdb2_valid (1), cdb2_tag (Q_WIDTH) and cdb2_value (32) for the load/store broadcast bus. Wake-up and dispatch bypass check both buses in the same cycle.
  - If both buses match the same operand tag, CDB2 wins (protocol error; must not hang).
  - Not defined: ports absent, single-CDB behaviour only.

Test Plan:
- Reset, then dispatch op=10'h080 (ADD), V1=5, V2=7, Q1=Q2=0, tag=3 → ex_valid=1 two edges after dispatch with ex_V1=5, ex_V2=7, ex_tag=3; entry freed.
- Dispatch Q1=4, V2=2; three cycles later CDB tag=4, value=0x10 → ex_valid one cycle after the broadcast with ex_V1=0x10; no issue before it.
- Dispatch with Q2=6 while cdb_valid, tag=6, value=0xABCD in the same cycle → bypass captured, issue with ex_V2=0xABCD, no further wait.
- Fill all 8 entries with Q1=9 → full=1, ninth dispatch ignored. Broadcast tag 9 → entries issue one per cycle in index order 0..7; full drops the cycle after the first issue.
- Four busy entries waiting, clear_in=1 → next cycle full=0, ex_valid=0, and a later CDB broadcast of their tags produces no issue.
- rdy_in=0 for 3 cycles with a ready entry and a CDB broadcast → no issue, no capture; resumes correctly when rdy_in=1.
